// File: rtl/ov5640_cfg_pkg.sv
// ov5640_cfg_pkg: shared state encoding and default timing for the OV5640 config sequencer.
package ov5640_cfg_pkg;
    typedef enum logic [3:0] {PWR_WAIT, LOAD, GAP, XFER, CHECK, NEXT, DELAY, DONE, ERROR} cfg_state_t;
    localparam logic [7:0] DLY_ID = 8'hFF;
    localparam int LUT_SIZE_D     = 256;
    localparam int IDX_W_D        = 8;
    localparam int PWR_DLY_D      = 20000;
    localparam int GAP_CYCLES_D   = 4;
    localparam int MAX_RETRY_D    = 3;
    localparam int XFER_TIMEOUT_D = 63;
    localparam int DLY_UNIT_D     = 100;
endpackage

// File: rtl/cfg_delay_timer.sv
// cfg_delay_timer: loadable 32-bit down-counter; expired while the count is 1 or 0,
// so a load of N keeps its owner waiting exactly N cycles (0 behaves as 1).
module cfg_delay_timer (
    input  logic        clk,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        expired
);
    logic [31:0] cnt;
    always_ff @(posedge clk)
        cnt <= load ? load_val : (cnt != 32'd0 ? cnt - 32'd1 : cnt);
    assign expired = cnt <= 32'd1;
endmodule

// File: rtl/ov5640_cfg_seq.sv
// ov5640_cfg_seq: walks the external register LUT and drives i2c_com one 32-bit write
// per entry, with NACK/timeout retries, in-table delays and done/error reporting.
module ov5640_cfg_seq
    import ov5640_cfg_pkg::*;
#(
    parameter int LUT_SIZE     = LUT_SIZE_D,
    parameter int IDX_W        = IDX_W_D,
    parameter int PWR_DLY      = PWR_DLY_D,
    parameter int GAP_CYCLES   = GAP_CYCLES_D,
    parameter int MAX_RETRY    = MAX_RETRY_D,
    parameter int XFER_TIMEOUT = XFER_TIMEOUT_D,
    parameter int DLY_UNIT     = DLY_UNIT_D
) (
    input  logic             clock_i2c,
    input  logic             camera_rst,
    input  logic             cfg_restart,
    output logic [IDX_W-1:0] lut_index,
    input  logic [31:0]      lut_data,
    output logic [31:0]      i2c_data,
    output logic             i2c_start,
    input  logic             i2c_tr_end,
    input  logic             i2c_ack,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_index
);
    cfg_state_t  state;
    logic [7:0]  retry;
    logic        timed_out, rs, expired, is_dly, ld;
    logic [31:0] dly, ld_val;

    assign rs     = camera_rst | cfg_restart;
    assign is_dly = lut_data[31:24] == DLY_ID;
    assign dly    = 32'(lut_data[15:0]) * 32'(DLY_UNIT);
    // CHECK always preloads the gap; harmless when the entry moves on instead of retrying
    assign ld     = rs | state == LOAD | (state == GAP && expired) | state == CHECK;
    assign ld_val = rs ? 32'(PWR_DLY) :
                    state == LOAD ? (is_dly ? dly : 32'(GAP_CYCLES)) :
                    state == GAP ? 32'(XFER_TIMEOUT) : 32'(GAP_CYCLES);

    cfg_delay_timer u_timer (
        .clk      (clock_i2c),
        .load     (ld),
        .load_val (ld_val),
        .expired  (expired)
    );

    always_ff @(posedge clock_i2c) begin
        if (rs) begin
            state     <= PWR_WAIT;
            lut_index <= '0;
            i2c_data  <= '0;
            i2c_start <= 1'b0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_index <= '0;
            retry     <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: if (expired) state <= LOAD;
                LOAD: begin
                    if (is_dly) state <= DELAY;
                    else begin
                        i2c_data <= lut_data;
                        state    <= GAP;
                    end
                end
                GAP: if (expired) begin
                    i2c_start <= 1'b1;
                    timed_out <= 1'b0;
                    state     <= XFER;
                end
                XFER: begin
                    if (i2c_tr_end) state <= CHECK;
                    else if (expired) begin
                        timed_out <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    i2c_start <= 1'b0;
                    if (!(i2c_ack || timed_out)) state <= NEXT;
                    else if (retry < 8'(MAX_RETRY)) begin
                        retry <= retry + 8'd1;
                        state <= GAP;
                    end else begin
                        err_index <= lut_index;
                        cfg_err   <= 1'b1;
                        cfg_busy  <= 1'b0;
                        state     <= ERROR;
                    end
                end
                NEXT: begin
                    retry <= '0;
                    if (lut_index == IDX_W'(LUT_SIZE - 1)) begin
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= DONE;
                    end else begin
                        lut_index <= lut_index + IDX_W'(1);
                        state     <= LOAD;
                    end
                end
                DELAY: if (expired) state <= NEXT;
                default: ;
            endcase
        end
    end
endmodule
